// File: rtl/tl_pkg.sv
// Shared traffic-light types and codes: controller state encoding, per-phase
// {R,Y,G} light codes and the mode encoding that selects manual operation.
package tl_pkg;

  localparam int unsigned LIGHT_W = 3;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned MODE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2,
    ST_ALL_RED = 2'd3
  } tl_state_t;

  localparam logic [LIGHT_W-1:0] LT_RED = 3'b100;
  localparam logic [LIGHT_W-1:0] LT_YEL = 3'b010;
  localparam logic [LIGHT_W-1:0] LT_GRN = 3'b001;

  localparam logic [MODE_W-1:0] MODE_MANUAL = 3'b001;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for a raw push button.
// rise_pulse is a registered 1-cycle pulse appearing 3 clk edges after
// async_in rises.
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   async_in   raw asynchronous input
//   rise_pulse 1-cycle pulse on a synchronised rising edge
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Metastability filter, edge history and registered pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync1_q    <= async_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      rise_pulse <= sync2_q & ~prev_q;
    end
  end

endmodule

// File: rtl/manual_phase_sequencer.sv
// Manual-mode traffic-light sequencer over NUM_PHASES phases. An operator
// button advances the green phase through a timed YELLOW (and, when the
// ALL_RED_CLEAR_EN macro is defined, a timed ALL_RED clearance) to the next
// phase, after a minimum green time has elapsed. Runs only while
// mode == MANUAL_CODE; otherwise it parks in IDLE with all lights red.
// Build option: `define ALL_RED_CLEAR_EN to insert the ALL_RED state.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   mode             system mode; block active when equal to MANUAL_CODE
//   tick             1-cycle time-base strobe for all timers
//   button           raw change-light request
//   min_green_time   minimum GREEN ticks before a change is honoured
//   yellow_time      YELLOW ticks (0 treated as 1)
//   allred_time      ALL_RED ticks (0 treated as 1), ALL_RED_CLEAR_EN only
//   lights           per-phase {R,Y,G}; phase p at [3p+2:3p]
//   active_phase     phase currently green or yellow
//   time_remain      ticks left in YELLOW/ALL_RED, all-ones otherwise
//   state            IDLE=0, GREEN=1, YELLOW=2, ALL_RED=3
//   req_pending      press latched, waiting for minimum green
module manual_phase_sequencer
  import tl_pkg::*;
#(
  parameter int unsigned        NUM_PHASES  = 2,
  parameter int unsigned        TIME_W      = 7,
  parameter logic [MODE_W-1:0]  MANUAL_CODE = MODE_MANUAL
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [MODE_W-1:0]               mode,
  input  logic                            tick,
  input  logic                            button,
  input  logic [TIME_W-1:0]               min_green_time,
  input  logic [TIME_W-1:0]               yellow_time,
  input  logic [TIME_W-1:0]               allred_time,
  output logic [LIGHT_W*NUM_PHASES-1:0]   lights,
  output logic [$clog2(NUM_PHASES)-1:0]   active_phase,
  output logic [TIME_W-1:0]               time_remain,
  output logic [STATE_W-1:0]              state,
  output logic                            req_pending
);

  localparam int unsigned PHASE_W = $clog2(NUM_PHASES);

  tl_state_t            state_q,  state_d;
  logic [PHASE_W-1:0]   phase_q,  phase_d;
  logic [TIME_W-1:0]    gtimer_q, gtimer_d;
  logic [TIME_W-1:0]    count_q,  count_d;
  logic                 req_q,    req_d;
  logic [LIGHT_W*NUM_PHASES-1:0] lights_d;
  logic [TIME_W-1:0]    time_remain_d;

  logic                 edge_pulse;
  logic                 green_met;
  logic [PHASE_W-1:0]   phase_next;
  logic [TIME_W-1:0]    yellow_load;

  btn_sync_edge u_btn (
    .clk        (clk),
    .reset      (reset),
    .async_in   (button),
    .rise_pulse (edge_pulse)
  );

  assign green_met   = (gtimer_q >= min_green_time);
  assign phase_next  = (phase_q == PHASE_W'(NUM_PHASES - 1)) ? '0 : phase_q + PHASE_W'(1);
  assign yellow_load = (yellow_time == '0) ? TIME_W'(1) : yellow_time;

`ifdef ALL_RED_CLEAR_EN
  logic [TIME_W-1:0] allred_load;
  assign allred_load = (allred_time == '0) ? TIME_W'(1) : allred_time;
`else
  logic unused_allred;
  assign unused_allred = ^allred_time;
`endif

  // State register plus registered light/countdown outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      gtimer_q    <= '0;
      count_q     <= '0;
      req_q       <= 1'b0;
      lights      <= {NUM_PHASES{LT_RED}};
      time_remain <= '1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      gtimer_q    <= gtimer_d;
      count_q     <= count_d;
      req_q       <= req_d;
      lights      <= lights_d;
      time_remain <= time_remain_d;
    end
  end

  // Next-state logic; mode exit overrides all tick/edge processing.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    gtimer_d = gtimer_q;
    count_d  = count_q;
    req_d    = req_q;

    if (mode != MANUAL_CODE) begin
      state_d  = ST_IDLE;
      gtimer_d = '0;
      count_d  = '0;
      req_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d  = ST_GREEN;
          phase_d  = '0;
          gtimer_d = '0;
          req_d    = 1'b0;
        end
        ST_GREEN: begin
          if ((edge_pulse || req_q) && green_met) begin
            state_d = ST_YELLOW;
            count_d = yellow_load;
            req_d   = 1'b0;
          end else begin
            if (edge_pulse) req_d = 1'b1;
            if (tick && (gtimer_q != '1)) gtimer_d = gtimer_q + TIME_W'(1);
          end
        end
        ST_YELLOW: begin
          if (tick) begin
            if (count_q == TIME_W'(1)) begin
`ifdef ALL_RED_CLEAR_EN
              state_d = ST_ALL_RED;
              count_d = allred_load;
`else
              state_d  = ST_GREEN;
              phase_d  = phase_next;
              gtimer_d = '0;
              req_d    = 1'b0;
`endif
            end else begin
              count_d = count_q - TIME_W'(1);
            end
          end
        end
        ST_ALL_RED: begin
          if (tick) begin
            if (count_q == TIME_W'(1)) begin
              state_d  = ST_GREEN;
              phase_d  = phase_next;
              gtimer_d = '0;
              req_d    = 1'b0;
            end else begin
              count_d = count_q - TIME_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode from next state so outputs align with the state register.
  always_comb begin
    lights_d      = {NUM_PHASES{LT_RED}};
    time_remain_d = '1;
    for (int unsigned p = 0; p < NUM_PHASES; p++) begin
      if (phase_d == PHASE_W'(p)) begin
        if (state_d == ST_GREEN)  lights_d[LIGHT_W*p +: LIGHT_W] = LT_GRN;
        if (state_d == ST_YELLOW) lights_d[LIGHT_W*p +: LIGHT_W] = LT_YEL;
      end
    end
    if ((state_d == ST_YELLOW) || (state_d == ST_ALL_RED)) time_remain_d = count_d;
  end

  assign active_phase = phase_q;
  assign state        = state_q;
  assign req_pending  = req_q;

endmodule

// File: tb/tb_manual_phase_sequencer.sv
// Bench for manual_phase_sequencer (3 phases): a cycle model pushes expected
// outputs each clock, a checker pops and compares them on the falling edge,
// and directed scenarios add explicit expectations on top.
module tb_manual_phase_sequencer;
  import tl_pkg::*;

  localparam int unsigned NP = 3;
  localparam int unsigned TW = 7;
  localparam int unsigned PW = $clog2(NP);
  localparam logic [3*NP-1:0] ALL_RED_L = {NP{LT_RED}};

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      mode;
  logic            tick;
  logic            button;
  logic [TW-1:0]   min_green_time;
  logic [TW-1:0]   yellow_time;
  logic [TW-1:0]   allred_time;
  logic [3*NP-1:0] lights;
  logic [PW-1:0]   active_phase;
  logic [TW-1:0]   time_remain;
  logic [1:0]      state;
  logic            req_pending;

  manual_phase_sequencer #(.NUM_PHASES(NP), .TIME_W(TW), .MANUAL_CODE(3'b001)) dut (
    .clk            (clk),
    .reset          (reset),
    .mode           (mode),
    .tick           (tick),
    .button         (button),
    .min_green_time (min_green_time),
    .yellow_time    (yellow_time),
    .allred_time    (allred_time),
    .lights         (lights),
    .active_phase   (active_phase),
    .time_remain    (time_remain),
    .state          (state),
    .req_pending    (req_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [3*NP-1:0] lights;
    logic [PW-1:0]   phase;
    logic [TW-1:0]   tr;
    logic [1:0]      st;
    logic            req;
  } exp_t;

  int m_state, m_phase, m_gt, m_cnt;
  bit m_req, m_s1, m_s2, m_s3, m_pulse;
  exp_t sb[$];

  task automatic model_reset();
    m_state = 0; m_phase = 0; m_gt = 0; m_cnt = 0; m_req = 0;
    m_s1 = 0; m_s2 = 0; m_s3 = 0; m_pulse = 0;
  endtask

  function automatic int min1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic enter_next_green();
    m_state = 1;
    m_phase = (m_phase == NP - 1) ? 0 : m_phase + 1;
    m_gt    = 0;
    m_req   = 0;
  endtask

  task automatic model_step();
    bit ev;
    ev = m_pulse;
    m_pulse = m_s2 && !m_s3;
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = button;
    if (mode != 3'b001) begin
      m_state = 0; m_gt = 0; m_cnt = 0; m_req = 0;
    end else begin
      case (m_state)
        0: begin m_state = 1; m_phase = 0; m_gt = 0; m_req = 0; end
        1: begin
          if ((ev || m_req) && (m_gt >= int'(min_green_time))) begin
            m_state = 2; m_cnt = min1(int'(yellow_time)); m_req = 0;
          end else begin
            if (ev) m_req = 1;
            if (tick && m_gt < 127) m_gt++;
          end
        end
        2: if (tick) begin
          if (m_cnt == 1) begin
`ifdef ALL_RED_CLEAR_EN
            m_state = 3; m_cnt = min1(int'(allred_time));
`else
            enter_next_green();
`endif
          end else m_cnt--;
        end
        default: if (tick) begin
          if (m_cnt == 1) enter_next_green();
          else m_cnt--;
        end
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.lights = ALL_RED_L;
    if (m_state == 1) e.lights[3*m_phase +: 3] = LT_GRN;
    if (m_state == 2) e.lights[3*m_phase +: 3] = LT_YEL;
    e.phase = PW'(m_phase);
    e.tr    = (m_state >= 2) ? TW'(m_cnt) : TW'(127);
    e.st    = 2'(m_state);
    e.req   = m_req;
    return e;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      model_step();
      sb.push_back(model_out());
    end
  end

  // Scoreboard compare plus lamp-safety invariants.
  always @(negedge clk) begin
    if (!reset) begin
      exp_t e;
      int nr;
      bit oh;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("sb_lights", 32'(lights), 32'(e.lights));
        check_eq("sb_phase",  32'(active_phase), 32'(e.phase));
        check_eq("sb_time_remain", 32'(time_remain), 32'(e.tr));
        check_eq("sb_state",  32'(state), 32'(e.st));
        check_eq("sb_req",    32'(req_pending), 32'(e.req));
      end
      nr = 0; oh = 1'b1;
      for (int p = 0; p < NP; p++) begin
        if (!$onehot(lights[3*p +: 3])) oh = 1'b0;
        if (lights[3*p +: 3] != LT_RED) nr++;
      end
      check_eq("lamp_onehot", 32'(oh), 32'd1);
      check_eq("single_nonred", 32'(nr <= 1), 32'd1);
    end
  end

  // ---------------- stimulus helpers ----------------
  int tick_div  = 4;
  int tcnt      = 0;
  bit tick_rand = 0;

  task automatic cyc();
    @(posedge clk); #2;
    tcnt++;
    if (tick_rand) tick = ($urandom_range(0, 2) == 0);
    else           tick = ((tcnt % tick_div) == 0);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] s, input int budget);
    int n;
    n = 0;
    while (state !== s && n < budget) begin cyc(); n++; end
    check_eq(tag, 32'(state), 32'(s));
  endtask

  task automatic press();
    button = 1'b1; cyc(); cyc(); cyc();
    button = 1'b0; cyc();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"},  32'(state), 32'd0);
    check_eq({tag, "_lights"}, 32'(lights), 32'(ALL_RED_L));
    check_eq({tag, "_tr"},     32'(time_remain), 32'h7F);
    check_eq({tag, "_req"},    32'(req_pending), 32'd0);
    check_eq({tag, "_phase"},  32'(active_phase), 32'd0);
  endtask

  initial begin
    int n;
    int cur;
    int seen[$];

    reset = 1'b1; mode = 3'b000; tick = 1'b0; button = 1'b0;
    min_green_time = 7'd3; yellow_time = 7'd4; allred_time = 7'd0;
    model_reset();
    #1;
    check_reset_outputs("por");
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b0;

    // min green with an early press latched as a request
    mode = 3'b001;
    cyc();
    wait_state("enter_green", 2'd1, 5);
    check_eq("green_phase0", 32'(active_phase), 32'd0);
    n = 0;
    while (m_gt != 1 && n < 50) begin cyc(); n++; end
    press();
    n = 0;
    while (req_pending !== 1'b1 && state == 2'd1 && n < 20) begin cyc(); n++; end
    check_eq("req_latched", 32'(req_pending), 32'd1);
    wait_state("to_yellow", 2'd2, 60);
    check_eq("yellow_phase0", 32'(active_phase), 32'd0);
    check_eq("yellow_lamp0", 32'(lights[2:0]), 32'(LT_YEL));
    check_eq("req_cleared", 32'(req_pending), 32'd0);

    // yellow countdown 4,3,2,1 then phase 1
    seen.delete();
    n = 0;
    while (state == 2'd2 && n < 100) begin
      if (seen.size() == 0 || seen[$] != int'(time_remain)) seen.push_back(int'(time_remain));
      cyc(); n++;
    end
    check_eq("yellow_steps", 32'(seen.size()), 32'd4);
    for (int i = 0; i < seen.size() && i < 4; i++) check_eq("yellow_count", 32'(seen[i]), 32'(4 - i));
`ifdef ALL_RED_CLEAR_EN
    check_eq("allred_state", 32'(state), 32'd3);
    check_eq("allred_tr", 32'(time_remain), 32'd1);
    check_eq("allred_lamps", 32'(lights), 32'(ALL_RED_L));
    wait_state("allred_exit", 2'd1, 20);
`else
    check_eq("after_yellow", 32'(state), 32'd1);
`endif
    check_eq("phase1_green", 32'(active_phase), 32'd1);

    // four full cycles with presses dropped during yellow/all-red
    cur = 1;
    for (int k = 0; k < 4; k++) begin
      press();
      wait_state("cyc_yellow", 2'd2, 60);
      check_eq("cyc_yellow_phase", 32'(active_phase), 32'(cur));
      press();
      wait_state("cyc_green", 2'd1, 100);
      cur = (cur + 1) % NP;
      check_eq("cyc_green_phase", 32'(active_phase), 32'(cur));
      check_eq("cyc_req_clear", 32'(req_pending), 32'd0);
    end

    // mode leaves manual mid-green, then returns
    repeat (3) cyc();
    mode = 3'b010;
    cyc();
    check_eq("mode_exit_state", 32'(state), 32'd0);
    check_eq("mode_exit_lights", 32'(lights), 32'(ALL_RED_L));
    check_eq("mode_exit_phase_held", 32'(active_phase), 32'(cur));
    check_eq("mode_exit_tr", 32'(time_remain), 32'h7F);
    mode = 3'b001;
    cyc();
    check_eq("mode_back_state", 32'(state), 32'd1);
    check_eq("mode_back_phase", 32'(active_phase), 32'd0);

    // asynchronous reset mid-yellow
    press();
    wait_state("pre_reset_yellow", 2'd2, 60);
    cyc();
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_yellow");
    model_reset();
    sb.delete();
    @(posedge clk); #2;
    reset = 1'b0;

    // green timer saturation with maximum min-green
    tick_rand = 1;
    min_green_time = 7'h7F;
    cyc(); cyc();
    press();
    wait_state("sat_yellow", 2'd2, 1500);

    // randomised soak
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if ($urandom_range(0, 3) == 0) button = ~button;
      if ($urandom_range(0, 199) == 0) mode = ($urandom_range(0, 2) == 0) ? 3'b010 : 3'b001;
      if ((c % 97) == 0) begin
        min_green_time = 7'($urandom_range(0, 5));
        yellow_time    = 7'($urandom_range(0, 5));
        allred_time    = 7'($urandom_range(0, 3));
      end
    end
    mode = 3'b001;
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
